song_player: RTL and testbench

- Sequencer stage that sits directly around the music-sheet ROM.
- Drives the ROM's 10-bit index, registers the returned note period and duration, and times each note.
- Generates the square-wave speaker output for the current note, then advances the index.
- Supports start, pause, stop and optional looping; feeds the board's speaker pin.

---
 rtl/song_player_pkg.sv | 21 ++
 rtl/song_player_if.sv | 30 +++
 rtl/song_player_tone_gen.sv | 51 +++++
 rtl/song_player.sv | 116 +++++++++++
 tb/tb_song_player.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/song_player_pkg.sv
// Shared definitions for the song sequencer: FSM state encoding and
// default song/timing constants.
package song_player_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_PLAY  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int DEF_EIGHTH_TICKS = 12_500_000;
   localparam int DEF_LAST_INDEX   = 44;
   localparam int DEF_IDX_W        = 10;
   localparam int DEF_NOTE_W       = 20;
   localparam int DEF_DUR_W        = 5;

   // Note half-periods at or below this value are silent rests.
   localparam int REST_NOTE = 1;

endpackage

// File: rtl/song_player_if.sv
// Control, ROM and speaker signals between the song player and its
// surroundings (player = slave, controller/ROM side = master).
interface song_player_if
   import song_player_pkg::*;
#(
   parameter int IDX_W  = DEF_IDX_W,
   parameter int NOTE_W = DEF_NOTE_W,
   parameter int DUR_W  = DEF_DUR_W
);
   logic              start;
   logic              pause;
   logic              stop;
   logic              loop_en;
   logic [NOTE_W-1:0] note_in;
   logic [DUR_W-1:0]  duration_in;
   logic [IDX_W-1:0]  number;
   logic              speaker;
   logic              playing;
   logic              done;

   modport slave (
      input  start, pause, stop, loop_en, note_in, duration_in,
      output number, speaker, playing, done
   );

   modport master (
      output start, pause, stop, loop_en, note_in, duration_in,
      input  number, speaker, playing, done
   );
endinterface

// File: rtl/song_player_tone_gen.sv
// Square-wave generator: toggles the speaker every note_i cycles while
// enabled; holds its phase when disabled and restarts on clear.
module tone_gen
   import song_player_pkg::*;
#(
   parameter int NOTE_W = DEF_NOTE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              clr_i,
   input  logic [NOTE_W-1:0] note_i,
   output logic              speaker_o
);
   logic [NOTE_W-1:0] tone_q, tone_d;
   logic              tgl_q, tgl_d;
   logic              isRest;

   assign isRest = (note_i <= NOTE_W'(REST_NOTE));

   always_comb begin
      tone_d = tone_q;
      tgl_d  = tgl_q;
      if (clr_i) begin
         tone_d = '0;
         tgl_d  = 1'b0;
      end else if (en_i) begin
         if (isRest) begin
            tone_d = '0;
         end else if (tone_q == note_i - NOTE_W'(1)) begin
            tone_d = '0;
            tgl_d  = ~tgl_q;
         end else begin
            tone_d = tone_q + NOTE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tone_q <= '0;
         tgl_q  <= 1'b0;
      end else begin
         tone_q <= tone_d;
         tgl_q  <= tgl_d;
      end
   end

   // The toggle flop keeps its phase across a pause; only the pin is muted.
   assign speaker_o = en_i && !isRest && tgl_q;
endmodule

// File: rtl/song_player.sv
// Song sequencer: walks the music ROM index, latches each note, times its
// duration in eighth-note units and drives the speaker tone generator.
module song_player
   import song_player_pkg::*;
#(
   parameter int EIGHTH_TICKS = DEF_EIGHTH_TICKS,
   parameter int LAST_INDEX   = DEF_LAST_INDEX,
   parameter int IDX_W        = DEF_IDX_W,
   parameter int NOTE_W       = DEF_NOTE_W,
   parameter int DUR_W        = DEF_DUR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   song_player_if.slave bus
);
   localparam int TICK_W = (EIGHTH_TICKS > 1) ? $clog2(EIGHTH_TICKS) : 1;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  number_q, number_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic [DUR_W-1:0]  dur_q, dur_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [DUR_W-1:0]  unit_q, unit_d;
   logic              tickWrap, noteEnd, toneEn;

   assign tickWrap = (tick_q == TICK_W'(EIGHTH_TICKS - 1));
   assign noteEnd  = tickWrap && (unit_q == dur_q - DUR_W'(1));

   always_comb begin
      state_d  = state_q;
      number_d = number_q;
      note_d   = note_q;
      dur_d    = dur_q;
      tick_d   = tick_q;
      unit_d   = unit_q;
      if (bus.stop) begin
         state_d  = ST_IDLE;
         number_d = '0;
         tick_d   = '0;
         unit_d   = '0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state_d  = ST_FETCH;
                  number_d = '0;
               end
            end
            ST_FETCH: begin
               note_d  = bus.note_in;
               dur_d   = (bus.duration_in == '0) ? DUR_W'(1) : bus.duration_in;
               tick_d  = '0;
               unit_d  = '0;
               state_d = ST_PLAY;
            end
            ST_PLAY: begin
               // Pause freezes both duration counters and the state.
               if (!bus.pause) begin
                  if (!tickWrap) begin
                     tick_d = tick_q + TICK_W'(1);
                  end else begin
                     tick_d = '0;
                     unit_d = unit_q + DUR_W'(1);
                     if (noteEnd) begin
                        unit_d = '0;
                        if (number_q < IDX_W'(LAST_INDEX)) begin
                           number_d = number_q + IDX_W'(1);
                           state_d  = ST_FETCH;
                        end else if (bus.loop_en) begin
                           number_d = '0;
                           state_d  = ST_FETCH;
                        end else begin
                           state_d = ST_DONE;
                        end
                     end
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         number_q <= '0;
         note_q   <= '0;
         dur_q    <= '0;
         tick_q   <= '0;
         unit_q   <= '0;
      end else begin
         state_q  <= state_d;
         number_q <= number_d;
         note_q   <= note_d;
         dur_q    <= dur_d;
         tick_q   <= tick_d;
         unit_q   <= unit_d;
      end
   end

   assign toneEn = (state_q == ST_PLAY) && !bus.pause;

   tone_gen #(.NOTE_W(NOTE_W)) u_tone (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_i      (toneEn),
      .clr_i     (state_q != ST_PLAY),
      .note_i    (note_q),
      .speaker_o (bus.speaker)
   );

   assign bus.number  = number_q;
   assign bus.playing = (state_q == ST_FETCH) || (state_q == ST_PLAY);
   assign bus.done    = (state_q == ST_DONE);
endmodule

// File: tb/tb_song_player.sv
// Self-checking bench for song_player: scripted and random control traffic
// compared every cycle against a note-timing model of the song.
module tb_song_player;
   localparam int ET   = 4;
   localparam int LAST = 3;

   localparam int M_IDLE  = 0;
   localparam int M_FETCH = 1;
   localparam int M_PLAY  = 2;
   localparam int M_DONE  = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   checkCount = 0;
   int   failCount  = 0;

   int romNotes[4] = '{5, 1, 3, 7};
   int romDurs[4]  = '{2, 1, 0, 3};

   int mMode, mIdx, mElapsed, mNote, mDur;
   int pauseLeft;

   song_player_if #(.IDX_W(10), .NOTE_W(20), .DUR_W(5)) spIf ();

   song_player #(
      .EIGHTH_TICKS (ET),
      .LAST_INDEX   (LAST),
      .IDX_W        (10),
      .NOTE_W       (20),
      .DUR_W        (5)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (spIf.slave)
   );

   always #5 clk = ~clk;

   // Stub ROM, combinational on the index the player drives.
   always_comb begin
      spIf.note_in     = '0;
      spIf.duration_in = '0;
      if (spIf.number <= 10'(LAST)) begin
         spIf.note_in     = 20'(romNotes[spIf.number[1:0]]);
         spIf.duration_in = 5'(romDurs[spIf.number[1:0]]);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelReset();
      mMode = M_IDLE; mIdx = 0; mElapsed = 0; mNote = 0; mDur = 0;
   endtask

   // Advances the model by one clock using the inputs seen at that edge.
   task automatic modelStep(input logic st, input logic pa, input logic sp, input logic lp);
      if (sp) begin
         mMode = M_IDLE; mIdx = 0; mElapsed = 0;
      end else begin
         case (mMode)
            M_IDLE, M_DONE: if (st) begin mMode = M_FETCH; mIdx = 0; end
            M_FETCH: begin
               mNote = romNotes[mIdx];
               mDur = (romDurs[mIdx] == 0) ? 1 : romDurs[mIdx];
               mElapsed = 0;
               mMode = M_PLAY;
            end
            default: begin
               if (!pa) begin
                  mElapsed++;
                  if (mElapsed == mDur * ET) begin
                     if (mIdx < LAST) begin mIdx++; mMode = M_FETCH; end
                     else if (lp) begin mIdx = 0; mMode = M_FETCH; end
                     else mMode = M_DONE;
                  end
               end
            end
         endcase
      end
   endtask

   task automatic checkAll(input logic pa);
      logic expSpk;
      expSpk = (mMode == M_PLAY) && !pa && (mNote > 1) && (((mElapsed / mNote) % 2) == 1);
      checkOutput("number", 32'(spIf.number), 32'(mIdx));
      checkOutput("speaker", 32'(spIf.speaker), 32'(expSpk));
      checkOutput("playing", 32'(spIf.playing), 32'((mMode == M_FETCH) || (mMode == M_PLAY)));
      checkOutput("done", 32'(spIf.done), 32'(mMode == M_DONE));
   endtask

   // Called just after a falling edge: drive, check, then cross the next rising edge.
   task automatic applyStimulus(input logic st, input logic pa, input logic sp, input logic lp);
      spIf.start = st; spIf.pause = pa; spIf.stop = sp; spIf.loop_en = lp;
      #1;
      checkAll(pa);
      @(posedge clk);
      modelStep(st, pa, sp, lp);
      @(negedge clk);
   endtask

   task automatic idleCycles(input int n, input logic lp);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, lp);
   endtask

   initial begin
      rst_n = 1'b0;
      spIf.start = 1'b0; spIf.pause = 1'b0; spIf.stop = 1'b0; spIf.loop_en = 1'b0;
      modelReset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      idleCycles(2, 1'b0);

      $display("[TB] full song, no loop");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(36, 1'b0);
      checkOutput("done_after_song", 32'(spIf.done), 32'd1);

      $display("[TB] looping with pause mid index 0");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
      idleCycles(7, 1'b1);
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
      idleCycles(45, 1'b1);

      $display("[TB] stop during index 2, then stop+start");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      idleCycles(16, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      idleCycles(2, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

      $display("[TB] async reset mid index 3");
      idleCycles(24, 1'b0);
      checkOutput("idx3_before_reset", 32'(spIf.number), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      modelReset();
      checkAll(1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idleCycles(2, 1'b0);

      $display("[TB] random traffic");
      pauseLeft = 0;
      for (int i = 0; i < 1500; i++) begin
         logic st, pa, sp, lp;
         st = ($urandom % 30) == 0;
         sp = ($urandom % 120) == 0;
         if (pauseLeft == 0 && ($urandom % 25) == 0) pauseLeft = $urandom_range(1, 8);
         pa = pauseLeft > 0;
         if (pauseLeft > 0) pauseLeft--;
         lp = ($urandom % 4) != 0;
         applyStimulus(st, pa, sp, lp);
      end

      $display("test done: total=%0d bad=%0d", checkCount, failCount);
      $finish;
   end
endmodule
